// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: parity encodings, frame limits,
// receive FSM states and the configuration legality check.
package uart_pkg;

  localparam logic [1:0] PAR_NONE    = 2'b00;
  localparam logic [1:0] PAR_ODD     = 2'b01;
  localparam logic [1:0] PAR_EVEN    = 2'b10;
  localparam logic [1:0] PAR_ILLEGAL = 2'b11;

  localparam int FRAME_MIN = 5;
  localparam int FRAME_MAX = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } rx_state_e;

  function automatic logic cfg_bad(input logic [3:0] fs, input logic [1:0] par);
    return (fs < 4'(FRAME_MIN)) || (fs > 4'(FRAME_MAX)) || (par == PAR_ILLEGAL);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic                         rd_valid,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign rd_valid = (count_q != '0);
  assign full     = (count_q == FULL_CNT);
  assign count    = count_q;
  // Empty FIFO shows zeros rather than stale storage.
  assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    do_pop   = pop && rd_valid;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (do_pop && !do_push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with configurable frame/parity feeding a FWFT FIFO
// of {perr, ferr, data} entries; sticky overrun when a frame meets a full FIFO.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int OVS   = 16,
  parameter int DIV_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [DIV_W-1:0]           div,
  input  logic [3:0]                 frame_size,
  input  logic [1:0]                 parity,
  input  logic                       rxd,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [7:0]                 rd_data,
  output logic                       rd_perr,
  output logic                       rd_ferr,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overrun,
  input  logic                       overrun_clr,
  output logic                       cfg_err,
  output rx_state_e                  dbg_state
);

  localparam int OS_W = $clog2(OVS);
  localparam logic [OS_W-1:0] HALF_LAST = OS_W'(OVS/2 - 1);
  localparam logic [OS_W-1:0] FULL_LAST = OS_W'(OVS - 1);

  rx_state_e        state_q, state_d;
  logic             sync1_q, sync1_d, sync2_q, sync2_d, rxd_prev_q, rxd_prev_d;
  logic [DIV_W-1:0] tick_cnt_q, tick_cnt_d, div_q, div_d;
  logic [OS_W-1:0]  os_cnt_q, os_cnt_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d, fsize_q, fsize_d;
  logic [7:0]       data_q, data_d;
  logic [1:0]       par_q, par_d;
  logic             perr_q, perr_d, cfg_err_q, cfg_err_d, overrun_q, overrun_d;
  logic             rxd_s, tick, push, fifo_full;
  logic [9:0]       push_data, fifo_rd;

  assign rxd_s     = sync2_q;
  assign tick      = (tick_cnt_q == div_q);
  assign cfg_err   = cfg_err_q;
  assign overrun   = overrun_q;
  assign dbg_state = state_q;
  assign rd_perr   = fifo_rd[9];
  assign rd_ferr   = fifo_rd[8];
  assign rd_data   = fifo_rd[7:0];

  always_comb begin
    state_d    = state_q;
    sync1_d    = rxd;
    sync2_d    = sync1_q;
    rxd_prev_d = sync2_q;
    tick_cnt_d = tick_cnt_q + DIV_W'(1);
    div_d      = div_q;
    os_cnt_d   = os_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    fsize_d    = fsize_q;
    data_d     = data_q;
    par_d      = par_q;
    perr_d     = perr_q;
    cfg_err_d  = cfg_bad(frame_size, parity);
    push       = 1'b0;
    push_data  = {perr_q, ~rxd_s, data_q};
    // A new divisor is only picked up at a wrap so a tick period is never torn.
    if (tick) begin
      tick_cnt_d = '0;
      div_d      = div;
    end

    unique case (state_q)
      ST_IDLE: begin
        // Edge detect, so a held-low break cannot retrigger a frame.
        if (en && !cfg_err_q && rxd_prev_q && !rxd_s) begin
          tick_cnt_d = '0;
          div_d      = div;
          os_cnt_d   = '0;
          bit_cnt_d  = '0;
          data_d     = '0;
          perr_d     = 1'b0;
          fsize_d    = frame_size;
          par_d      = parity;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          if (os_cnt_q == HALF_LAST) begin
            os_cnt_d = '0;
            state_d  = rxd_s ? ST_IDLE : ST_DATA;
          end else begin
            os_cnt_d = os_cnt_q + OS_W'(1);
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (os_cnt_q == FULL_LAST) begin
            os_cnt_d                = '0;
            data_d[bit_cnt_q[2:0]]  = rxd_s;
            bit_cnt_d               = bit_cnt_q + 4'd1;
            if (bit_cnt_q == fsize_q - 4'd1)
              state_d = (par_q != PAR_NONE) ? ST_PAR : ST_STOP;
          end else begin
            os_cnt_d = os_cnt_q + OS_W'(1);
          end
        end
      end
      ST_PAR: begin
        if (tick) begin
          if (os_cnt_q == FULL_LAST) begin
            os_cnt_d = '0;
            perr_d   = (par_q == PAR_ODD) ? ~(^data_q ^ rxd_s) : (^data_q ^ rxd_s);
            state_d  = ST_STOP;
          end else begin
            os_cnt_d = os_cnt_q + OS_W'(1);
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (os_cnt_q == FULL_LAST) begin
            os_cnt_d = '0;
            push     = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            os_cnt_d = os_cnt_q + OS_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!en) begin
      state_d = ST_IDLE;
      push    = 1'b0;
    end
    // A fresh overrun in the same cycle as a clear must survive.
    overrun_d = (overrun_q && !overrun_clr) || (push && fifo_full && !(rd_valid && rd_ready));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rxd_prev_q <= 1'b1;
      tick_cnt_q <= '0;
      div_q      <= div;
      os_cnt_q   <= '0;
      bit_cnt_q  <= '0;
      fsize_q    <= 4'(FRAME_MAX);
      data_q     <= '0;
      par_q      <= PAR_NONE;
      perr_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      rxd_prev_q <= rxd_prev_d;
      tick_cnt_q <= tick_cnt_d;
      div_q      <= div_d;
      os_cnt_q   <= os_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      fsize_q    <= fsize_d;
      data_q     <= data_d;
      par_q      <= par_d;
      perr_q     <= perr_d;
      cfg_err_q  <= cfg_err_d;
      overrun_q  <= overrun_d;
    end
  end

  sync_fifo #(.WIDTH(10), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (rd_ready),
    .rd_valid  (rd_valid),
    .rd_data   (fifo_rd),
    .full      (fifo_full),
    .count     (count)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed + randomized bench for uart_rx_fifo: serial frames are built from
// the line protocol and results compared against a queue model of the FIFO.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 8;
  localparam int OVS   = 16;
  localparam int DIV_W = 16;
  localparam int CW    = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             rst, en, rxd, rd_ready, overrun_clr;
  logic [DIV_W-1:0] div;
  logic [3:0]       frame_size;
  logic [1:0]       parity;
  logic             rd_valid, rd_perr, rd_ferr, overrun, cfg_err;
  logic [7:0]       rd_data;
  logic [CW-1:0]    count;
  rx_state_e        dbg_state;

  uart_rx_fifo #(.DEPTH(DEPTH), .OVS(OVS), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst(rst), .en(en), .div(div), .frame_size(frame_size),
    .parity(parity), .rxd(rxd), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_perr(rd_perr), .rd_ferr(rd_ferr), .count(count),
    .overrun(overrun), .overrun_clr(overrun_clr), .cfg_err(cfg_err),
    .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #(900_000);
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  int         checks   = 0;
  int         failures = 0;
  logic [9:0] exp_q[$];
  logic       exp_overrun;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int bit_clks();
    return OVS * (int'(div) + 1);
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rxd = b;
    cyc(bit_clks());
  endtask

  task automatic model_push(input logic [9:0] e);
    if (exp_q.size() < DEPTH) exp_q.push_back(e);
    else exp_overrun = 1'b1;
  endtask

  // Serialize one frame; the expected entry is derived from the line contents.
  task automatic send_frame(input logic [7:0] data, input int nbits, input logic [1:0] pmode,
                            input logic bad_par, input logic stop_bit, input int idle_bits,
                            input logic expect_push);
    logic [7:0] d;
    logic [7:0] mask;
    logic       pbit, perr;
    int         ones;
    mask = 8'((1 << nbits) - 1);
    d    = data & mask;
    ones = $countones(d);
    perr = 1'b0;
    drive_bit(1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(d[i]);
    if (pmode != PAR_NONE) begin
      pbit = (pmode == PAR_ODD) ? ((ones % 2) == 0) : ((ones % 2) == 1);
      if (bad_par) pbit = ~pbit;
      perr = (pmode == PAR_ODD) ? (((ones + int'(pbit)) % 2) == 0) : (((ones + int'(pbit)) % 2) == 1);
      drive_bit(pbit);
    end
    drive_bit(stop_bit);
    for (int i = 0; i < idle_bits; i++) drive_bit(1'b1);
    if (expect_push) model_push({perr, ~stop_bit, d});
  endtask

  task automatic check_status(input string tag);
    check({tag, "_count"}, 32'(count), 32'(exp_q.size()));
    check({tag, "_valid"}, 32'(rd_valid), 32'(exp_q.size() > 0));
    check({tag, "_overrun"}, 32'(overrun), 32'(exp_overrun));
  endtask

  task automatic pop_check(input string tag);
    logic [9:0] h;
    check({tag, "_valid"}, 32'(rd_valid), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      h = exp_q.pop_front();
      check({tag, "_data"}, 32'(rd_data), 32'(h[7:0]));
      check({tag, "_perr"}, 32'(rd_perr), 32'(h[9]));
      check({tag, "_ferr"}, 32'(rd_ferr), 32'(h[8]));
      rd_ready = 1'b1;
      cyc(1);
      rd_ready = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] d;
    logic       seen;
    rst = 1'b1; en = 1'b1; rxd = 1'b1; rd_ready = 1'b0; overrun_clr = 1'b0;
    div = 16'd3; frame_size = 4'd8; parity = PAR_NONE; exp_overrun = 1'b0;
    cyc(3);
    check("rst_count", 32'(count), 0);
    check("rst_valid", 32'(rd_valid), 0);
    check("rst_data", 32'(rd_data), 0);
    check("rst_perr", 32'(rd_perr), 0);
    check("rst_ferr", 32'(rd_ferr), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_cfg_err", 32'(cfg_err), 0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    cyc(4);

    // 8N frame 0xF0
    send_frame(8'hF0, 8, PAR_NONE, 1'b0, 1'b1, 2, 1'b1);
    check("f0_count", 32'(count), 1);
    check("f0_data_const", 32'(rd_data), 32'h0F0);
    pop_check("f0");

    // pop request on empty FIFO
    rd_ready = 1'b1; cyc(1); rd_ready = 1'b0;
    check_status("empty_pop");

    // 5-bit odd parity, good then bad parity bit
    frame_size = 4'd5; parity = PAR_ODD; cyc(2);
    send_frame(8'h07, 5, PAR_ODD, 1'b0, 1'b1, 2, 1'b1);
    check("odd_good_data", 32'(rd_data), 32'h07);
    check("odd_good_perr", 32'(rd_perr), 0);
    pop_check("odd_good");
    send_frame(8'h07, 5, PAR_ODD, 1'b1, 1'b1, 2, 1'b1);
    check("odd_bad_perr", 32'(rd_perr), 1);
    pop_check("odd_bad");

    // config change mid-frame must not disturb the frame in flight
    frame_size = 4'd8; parity = PAR_EVEN; cyc(2);
    fork
      send_frame(8'hA5, 8, PAR_EVEN, 1'b0, 1'b1, 2, 1'b1);
      begin cyc(3 * bit_clks()); frame_size = 4'd5; parity = PAR_NONE; end
    join
    pop_check("midcfg");
    frame_size = 4'd8; parity = PAR_NONE; cyc(2);

    // fill past DEPTH without popping
    for (int i = 0; i < 9; i++) send_frame(8'($urandom), 8, PAR_NONE, 1'b0, 1'b1, 1, 1'b1);
    check_status("full");
    check("full_head", 32'(rd_data), 32'(exp_q[0][7:0]));

    // pop exactly in the cycle frame 10 is pushed
    d = 8'($urandom);
    fork
      send_frame(d, 8, PAR_NONE, 1'b0, 1'b1, 1, 1'b1);
      begin
        seen = 1'b0;
        for (int i = 0; i < 20 * bit_clks() && !seen; i++) begin
          @(posedge clk); #1;
          if (dbg_state == ST_STOP) seen = 1'b1;
        end
        check("stop_seen", 32'(seen), 1);
        repeat (bit_clks() - 1) @(posedge clk);
        #1;
        rd_ready = 1'b1;
        cyc(1);
        rd_ready = 1'b0;
        void'(exp_q.pop_front());
      end
    join
    check_status("full_pushpop");
    check("frame10_tail", 32'(exp_q[DEPTH-1][7:0]), 32'(d));
    for (int i = 0; i < DEPTH; i++) pop_check("drain_full");
    overrun_clr = 1'b1; cyc(1); overrun_clr = 1'b0; exp_overrun = 1'b0;
    check_status("ovr_clr");

    // break: stop bit low, line held low for 20 bit times
    send_frame(8'h00, 8, PAR_NONE, 1'b0, 1'b0, 0, 1'b1);
    for (int i = 0; i < 19; i++) drive_bit(1'b0);
    check_status("break_low");
    check("break_ferr", 32'(rd_ferr), 1);
    drive_bit(1'b1); drive_bit(1'b1);
    check_status("break_high");
    pop_check("break");
    send_frame(8'h3C, 8, PAR_NONE, 1'b0, 1'b1, 2, 1'b1);
    pop_check("after_break");

    // illegal configurations receive nothing
    frame_size = 4'd9; cyc(3);
    check("cfg_fs9", 32'(cfg_err), 1);
    send_frame(8'h55, 8, PAR_NONE, 1'b0, 1'b1, 2, 1'b0);
    check_status("cfg_fs9");
    frame_size = 4'd8; parity = PAR_ILLEGAL; cyc(3);
    check("cfg_par11", 32'(cfg_err), 1);
    send_frame(8'h55, 8, PAR_NONE, 1'b0, 1'b1, 2, 1'b0);
    check_status("cfg_par11");
    parity = PAR_NONE; cyc(3);
    check("cfg_ok", 32'(cfg_err), 0);

    // reset during DATA clears FIFO and aborts the frame
    send_frame(8'h81, 8, PAR_NONE, 1'b0, 1'b1, 2, 1'b1);
    drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b0);
    rst = 1'b1; rxd = 1'b1; cyc(2); rst = 1'b0;
    exp_q.delete();
    check("rst_mid_state", 32'(dbg_state), 32'(ST_IDLE));
    check_status("rst_mid");
    drive_bit(1'b1); drive_bit(1'b1);
    send_frame(8'h6B, 8, PAR_NONE, 1'b0, 1'b1, 2, 1'b1);
    pop_check("after_rst");

    // disable mid-frame: partial frame discarded, FIFO retained
    send_frame(8'h19, 8, PAR_NONE, 1'b0, 1'b1, 2, 1'b1);
    drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b0);
    en = 1'b0; cyc(2);
    check("dis_state", 32'(dbg_state), 32'(ST_IDLE));
    for (int i = 0; i < 10; i++) drive_bit(1'b1);
    en = 1'b1; cyc(2);
    check_status("dis");
    pop_check("dis");

    // randomized frames with random pops
    div = 16'd1; cyc(8);
    for (int n = 0; n < 30; n++) begin
      int         fs;
      logic [1:0] pm;
      fs = $urandom_range(5, 8);
      pm = 2'($urandom_range(0, 2));
      frame_size = 4'(fs); parity = pm; cyc(2);
      send_frame(8'($urandom), fs, pm, ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 5) != 0), 2, 1'b1);
      check_status("rand");
      if ($urandom_range(0, 2) != 0) pop_check("rand_pop");
    end
    while (exp_q.size() > 0) pop_check("rand_drain");
    check_status("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
